// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit serializer.
// The optional parity stage is controlled by the UART_TX_PARITY_EN macro
// in the files that use this package.
package uart_pkg;

    // Transmit FSM states. The top module mirrors these as plain
    // localparam constants so the state register stays a bare vector.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Level of the serial line between frames and during stop bits.
    localparam logic UART_IDLE_LVL = 1'b1;

    // Per-frame configuration, captured at the handshake and held for the frame.
    typedef struct packed {
        logic two_stop;
        logic parity_en;
        logic parity_odd;
    } uart_frame_cfg_t;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer_if.sv
// Word handshake between the TX FIFO/register block (master) and the
// serializer (slave). Transfer happens on a clock edge with valid && ready.
interface uart_tx_serializer_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface : uart_tx_serializer_if

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter. Loaded with (clocks per bit - 1) at the
// start of every bit; o_bit_end is high in the last clock of the bit.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    output logic             o_bit_end
);

    logic [DIV_W-1:0] r_cnt;

    // Count down through the bit period; a load restarts the period.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    // A divisor of 0 gives a counter that is already 0: one clock per bit.
    assign o_bit_end = i_en && (r_cnt == '0);

endmodule : uart_baud_tick

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W data bits LSB first, optional
// parity bit, 1 or 2 stop bits. o_tx is registered and idles high.
// Optional feature macro: UART_TX_PARITY_EN compiles in the PARITY state;
// without it i_parity_en / i_parity_odd are accepted but ignored.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic             i_two_stop,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    uart_tx_serializer_if.slave s_if,
    output logic             o_tx,
    output logic             o_busy
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_idx;
    logic              r_stop_idx;
    uart_frame_cfg_t   r_cfg;
    logic [DIV_W-1:0]  r_div;
    logic              r_tx;
`ifdef UART_TX_PARITY_EN
    logic              r_par_acc;
`endif

    logic              w_bit_end;
    logic              w_frame_done;
    logic              w_ready;
    logic              w_xfer;
    logic              w_load;
    logic [DIV_W-1:0]  w_load_val;

`ifndef UART_TX_PARITY_EN
    // Parity configuration is still latched so both builds share one
    // datapath, but nothing reads it when parity is compiled out.
    logic w_unused_parity_cfg;
    assign w_unused_parity_cfg = r_cfg.parity_en ^ r_cfg.parity_odd;
`endif

    // Last clock of the last stop bit: the frame is finishing and a new word
    // can be taken without an idle gap.
    assign w_frame_done = (r_state == ST_STOP) && w_bit_end
                          && (r_stop_idx || !r_cfg.two_stop);
    assign w_ready      = (r_state == ST_IDLE) || w_frame_done;
    assign w_xfer       = s_if.valid && w_ready;

    // Reload the bit timer at every bit start, including a back-to-back
    // START where the freshly presented divisor applies.
    assign w_load       = w_xfer || (w_bit_end && !w_frame_done);
    assign w_load_val   = w_xfer ? i_baud_div : r_div;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_en       (r_state != ST_IDLE),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_bit_end  (w_bit_end)
    );

    // Frame FSM: latch word and config on transfer, then step one bit per
    // bit period, driving the registered line level for the next bit.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= ST_IDLE;
            r_tx       <= UART_IDLE_LVL;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_cfg      <= '0;
            r_div      <= '0;
`ifdef UART_TX_PARITY_EN
            r_par_acc  <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_state    <= ST_START;
            r_tx       <= ~UART_IDLE_LVL;
            r_shift    <= s_if.data;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_div      <= i_baud_div;
            r_cfg      <= '{two_stop:   i_two_stop,
                            parity_en:  i_parity_en,
                            parity_odd: i_parity_odd};
`ifdef UART_TX_PARITY_EN
            r_par_acc  <= 1'b0;
`endif
        end else if (w_bit_end) begin
            case (r_state)
                ST_START: begin
                    r_state <= ST_DATA;
                    r_tx    <= r_shift[0];
                end
                ST_DATA: begin
`ifdef UART_TX_PARITY_EN
                    r_par_acc <= r_par_acc ^ r_shift[0];
`endif
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        if (r_cfg.parity_en) begin
                            r_state <= ST_PARITY;
                            r_tx    <= r_par_acc ^ r_shift[0] ^ r_cfg.parity_odd;
                        end else
`endif
                        begin
                            r_state    <= ST_STOP;
                            r_tx       <= UART_IDLE_LVL;
                            r_stop_idx <= 1'b0;
                        end
                    end else begin
                        r_bit_idx <= r_bit_idx + BIT_W'(1);
                        r_shift   <= r_shift >> 1;
                        r_tx      <= r_shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    r_state    <= ST_STOP;
                    r_tx       <= UART_IDLE_LVL;
                    r_stop_idx <= 1'b0;
                end
`endif
                ST_STOP: begin
                    if (w_frame_done) begin
                        r_state <= ST_IDLE;
                        r_tx    <= UART_IDLE_LVL;
                    end else begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= UART_IDLE_LVL;
                end
            endcase
        end
    end

    assign s_if.ready = w_ready;
    assign o_tx       = r_tx;
    assign o_busy     = (r_state != ST_IDLE);

endmodule : uart_tx_serializer

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: fixed frame vectors, hand
// sequences for back-to-back, mid-frame input changes and mid-frame reset,
// then randomized frames against a frame-level reference model.
module tb_uart_tx_serializer;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [DIV_W-1:0] baud_div;
    logic             two_stop;
    logic             par_en;
    logic             par_odd;
    logic             tx;
    logic             busy;

    uart_tx_serializer_if #(.DATA_W(DATA_W)) u_if ();

    uart_tx_serializer #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_baud_div   (baud_div),
        .i_two_stop   (two_stop),
        .i_parity_en  (par_en),
        .i_parity_odd (par_odd),
        .s_if         (u_if),
        .o_tx         (tx),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic cap_tx[$];
    bit   exp_tx[$];
    int   cap_busy;
    int   cap_rdy_hi;

    typedef struct {
        logic [7:0]       data;
        logic [DIV_W-1:0] div;
        logic             two;
        logic             pe;
        logic             po;
        int               nbits;
        logic [11:0]      bits;   // bit i = expected line level of frame bit i
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference frame: list of bit levels from the framing rules, each
    // stretched to div+1 clocks, appended to exp_tx.
    task automatic model_frame(input logic [7:0] d, input int div,
                               input bit two, input bit pe, input bit po);
        bit lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) lv.push_back(d[i]);
        if (PAR_ON && pe) lv.push_back(bit'($countones(d) % 2) ^ po);
        lv.push_back(1'b1);
        if (two) lv.push_back(1'b1);
        foreach (lv[k]) repeat (div + 1) exp_tx.push_back(lv[k]);
    endtask

    function automatic int count_diff();
        int n = 0;
        int m = (cap_tx.size() < exp_tx.size()) ? cap_tx.size() : exp_tx.size();
        for (int i = 0; i < m; i++) if (cap_tx[i] !== exp_tx[i]) n++;
        n += (cap_tx.size() > exp_tx.size()) ? cap_tx.size() - m : exp_tx.size() - m;
        return n;
    endfunction

    // Present a word at a negedge with the DUT idle; transfer on next posedge.
    task automatic send(input logic [7:0] d, input logic [DIV_W-1:0] div,
                        input logic two, input logic pe, input logic po);
        @(negedge clk);
        check("ready_at_send", u_if.ready, 1);
        u_if.data  = d;
        baud_div   = div;
        two_stop   = two;
        par_en     = pe;
        par_odd    = po;
        u_if.valid = 1'b1;
        @(posedge clk);
    endtask

    // Sample the line once per clock on negedges after the transfer edge.
    task automatic capture(input int ncyc, input int perturb_at, input int drop_at);
        cap_tx.delete();
        cap_busy   = 0;
        cap_rdy_hi = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cap_tx.push_back(tx);
            if (busy === 1'b1) cap_busy++;
            if (u_if.ready === 1'b1) cap_rdy_hi++;
            if (i == drop_at) u_if.valid = 1'b0;
            if (i == perturb_at) begin
                u_if.data = 8'($urandom);
                baud_div  = DIV_W'($urandom_range(0, 3));
                two_stop  = ~two_stop;
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_idle_tx"}, tx, 1);
        check({name, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [7:0]       nd;
        logic [DIV_W-1:0] ndiv;
        logic             ntwo;
        int               len;
        int               zeros;
        int               bcnt;

        vecs[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 10, 12'h34A};
`ifdef UART_TX_PARITY_EN
        vecs[1] = '{8'hFF, 16'd2, 1'b0, 1'b1, 1'b0, 11, 12'h5FE};
        vecs[2] = '{8'h07, 16'd0, 1'b0, 1'b1, 1'b0, 11, 12'h60E};
        vecs[3] = '{8'h07, 16'd0, 1'b0, 1'b1, 1'b1, 11, 12'h40E};
`else
        vecs[1] = '{8'hFF, 16'd2, 1'b0, 1'b1, 1'b0, 10, 12'h3FE};
        vecs[2] = '{8'h07, 16'd0, 1'b0, 1'b1, 1'b0, 10, 12'h20E};
        vecs[3] = '{8'h07, 16'd0, 1'b0, 1'b1, 1'b1, 10, 12'h20E};
`endif
        vecs[4] = '{8'h00, 16'd1, 1'b1, 1'b0, 1'b0, 11, 12'h600};
        vecs[5] = '{8'h80, 16'd0, 1'b0, 1'b0, 1'b0, 10, 12'h300};

        u_if.data  = '0;
        u_if.valid = 1'b0;
        baud_div   = '0;
        two_stop   = 1'b0;
        par_en     = 1'b0;
        par_odd    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_ready", u_if.ready, 1);
        check("rst_rel_tx", tx, 1);

        // Fixed frame vectors
        for (int v = 0; v < 6; v++) begin
            len = (int'(vecs[v].div) + 1) * vecs[v].nbits;
            exp_tx.delete();
            for (int c = 0; c < len; c++)
                exp_tx.push_back(vecs[v].bits[c / (int'(vecs[v].div) + 1)]);
            send(vecs[v].data, vecs[v].div, vecs[v].two, vecs[v].pe, vecs[v].po);
            capture(len, -1, 0);
            check($sformatf("vec%0d_bits", v), count_diff(), 0);
            check($sformatf("vec%0d_busy_clks", v), cap_busy, len);
            check($sformatf("vec%0d_ready_low_clks", v), len - cap_rdy_hi, len - 1);
            check_idle($sformatf("vec%0d", v));
        end

        // Back-to-back: valid held high, 0x11 then 0x22, div=1, two stop bits
        send(8'h11, 16'd1, 1'b1, 1'b0, 1'b0);
        #1 u_if.data = 8'h22;
        exp_tx.delete();
        model_frame(8'h11, 1, 1'b1, 1'b0, 1'b0);
        len = exp_tx.size();
        model_frame(8'h22, 1, 1'b1, 1'b0, 1'b0);
        capture(2 * len, -1, len);
        check("b2b_bits", count_diff(), 0);
        check("b2b_busy_clks", cap_busy, 2 * len);
        check("b2b_ready_hi_clks", cap_rdy_hi, 2);
        check("b2b_second_start", cap_tx[len], 0);
        check_idle("b2b");

        // Inputs changed mid-frame do not disturb the frame in flight
        send(8'h3C, 16'd2, 1'b0, 1'b0, 1'b0);
        exp_tx.delete();
        model_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0);
        capture(exp_tx.size(), 5, 0);
        check("midchg_bits", count_diff(), 0);
        check("midchg_busy_clks", cap_busy, exp_tx.size());
        check_idle("midchg");
        nd   = u_if.data;
        ndiv = baud_div;
        ntwo = two_stop;
        exp_tx.delete();
        model_frame(nd, int'(ndiv), ntwo, 1'b0, 1'b0);
        send(nd, ndiv, ntwo, 1'b0, 1'b0);
        capture(exp_tx.size(), -1, 0);
        check("midchg_next_bits", count_diff(), 0);
        check("midchg_next_busy_clks", cap_busy, exp_tx.size());
        check_idle("midchg_next");

        // Reset in the middle of data bit 3 (div=3: samples 16..19)
        send(8'h00, 16'd3, 1'b0, 1'b0, 1'b0);
        capture(18, -1, 0);
        check("rstmid_pre_tx", cap_tx[17], 0);
        nrst = 1'b0;
        #1;
        check("rstmid_tx", tx, 1);
        check("rstmid_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("rstmid_ready", u_if.ready, 1);
        check("rstmid_rel_busy", busy, 0);
        zeros = 0;
        bcnt  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
            if (busy !== 1'b0) bcnt++;
        end
        check("rstmid_residual_bits", zeros, 0);
        check("rstmid_residual_busy", bcnt, 0);

        // Randomized frames against the reference model
        for (int r = 0; r < 20; r++) begin
            nd   = 8'($urandom);
            ndiv = DIV_W'($urandom_range(0, 3));
            ntwo = 1'($urandom);
            exp_tx.delete();
            begin
                logic pe_r;
                logic po_r;
                pe_r = 1'($urandom);
                po_r = 1'($urandom);
                model_frame(nd, int'(ndiv), ntwo, pe_r, po_r);
                send(nd, ndiv, ntwo, pe_r, po_r);
            end
            capture(exp_tx.size(), -1, 0);
            check($sformatf("rand%0d_bits", r), count_diff(), 0);
            check($sformatf("rand%0d_busy_clks", r), cap_busy, exp_tx.size());
            check_idle($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_serializer
